// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: lets two writeback requesters share the single register-file
// write port. The requesters are ALU results (a_*) and load data (m_*).
// Loads win by default. The ALU gets the port after STARVE_MAX consecutive
// losses. WE3/A3/WD3/grant_m are registered and drive the register file
// directly. Nothing is buffered: a request that loses arbitration waits at
// its source.
module rf_wb_arbiter #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic              m_valid,
  output logic              m_ready,
  input  logic [ADDR_W-1:0] m_addr,
  input  logic [DATA_W-1:0] m_data,
  output logic              WE3,
  output logic [ADDR_W-1:0] A3,
  output logic [DATA_W-1:0] WD3,
  output logic              grant_m
);

  // Guard against a zero-width counter if STARVE_MAX is ever set to 0.
  localparam int unsigned CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0]  starve_q, starve_d;
  logic              a_xfer, m_xfer, any_xfer;
  logic              a_aged;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  logic              we3_q, we3_d;
  logic [ADDR_W-1:0] a3_q, a3_d;
  logic [DATA_W-1:0] wd3_q, wd3_d;
  logic              grant_m_q, grant_m_d;

  // Arbitration. ready depends only on both valids and the age count, never on
  // a payload. Both readies are forced low while reset is asserted.
  always_comb begin
    a_aged  = (starve_q == STARVE_LIM);
    a_ready = rst & a_valid & (~m_valid | a_aged);
    m_ready = rst & m_valid & (~a_valid | ~a_aged);
  end

  // Transfer decode and selection of the winning payload.
  always_comb begin
    a_xfer   = a_valid & a_ready;
    m_xfer   = m_valid & m_ready;
    any_xfer = a_xfer | m_xfer;
    sel_addr = m_xfer ? m_addr : a_addr;
    sel_data = m_xfer ? m_data : a_data;
  end

  // Age count: counts ALU losses and saturates at the limit. It clears once
  // the ALU is served or stops asking.
  always_comb begin
    starve_d = starve_q;
    if (!a_valid || a_xfer) begin
      starve_d = '0;
    end else if (starve_q != STARVE_LIM) begin
      starve_d = starve_q + CNT_W'(1);
    end
  end

  // Next write-port state. A transfer to x0 is accepted but does not write,
  // so the previous A3/WD3/grant_m are kept.
  always_comb begin
    we3_d     = 1'b0;
    a3_d      = a3_q;
    wd3_d     = wd3_q;
    grant_m_d = grant_m_q;
    if (any_xfer && (sel_addr != '0)) begin
      we3_d     = 1'b1;
      a3_d      = sel_addr;
      wd3_d     = sel_data;
      grant_m_d = m_xfer;
    end
  end

  // State registers, cleared asynchronously on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_q  <= '0;
      we3_q     <= 1'b0;
      a3_q      <= '0;
      wd3_q     <= '0;
      grant_m_q <= 1'b0;
    end else begin
      starve_q  <= starve_d;
      we3_q     <= we3_d;
      a3_q      <= a3_d;
      wd3_q     <= wd3_d;
      grant_m_q <= grant_m_d;
    end
  end

  // Registered write port to the register file.
  always_comb begin
    WE3     = we3_q;
    A3      = a3_q;
    WD3     = wd3_q;
    grant_m = grant_m_q;
  end

endmodule
